// File: rtl/cc_serial.sv
// cc_serial: serial four-beat operand collector followed by a fixed-latency
// sort / mean-removal / arithmetic pipeline sequenced by a single FSM.
// One result strobe is produced per four accepted beats.
module cc_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    input  logic [3:0] opt,
    output logic       in_ready,
    output logic       out_valid,
    output logic [8:0] out_n
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SORT,
        MEAN,
        CALC,
        OUT
    } state_t;

    state_t            state;
    logic signed [3:0] n      [4];
    logic signed [3:0] n_sort [4];
    logic signed [4:0] r      [4];
    logic signed [4:0] r_next [4];
    logic        [3:0] op;
    logic        [1:0] cnt;        // beat index while loading, phase while sorting

    logic signed [5:0]  sum;
    logic signed [5:0]  sum_adj;
    logic signed [3:0]  mean;
    logic signed [11:0] prod_a;
    logic signed [11:0] prod_b;
    logic signed [11:0] result;

    // True when the pair (a, b) violates the requested order.
    function automatic logic out_of_order(input logic signed [3:0] a,
                                          input logic signed [3:0] b,
                                          input logic              asc);
        return asc ? (a > b) : (a < b);
    endfunction

    assign in_ready = (state == IDLE) || (state == LOAD);

    // One odd-even transposition phase; even phases use pairs (0,1)(2,3), odd phases (1,2).
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            n_sort[i] = n[i];
        end
        if (op[0]) begin
            if (!cnt[0]) begin
                if (out_of_order(n[0], n[1], op[1])) begin
                    n_sort[0] = n[1];
                    n_sort[1] = n[0];
                end
                if (out_of_order(n[2], n[3], op[1])) begin
                    n_sort[2] = n[3];
                    n_sort[3] = n[2];
                end
            end else if (out_of_order(n[1], n[2], op[1])) begin
                n_sort[1] = n[2];
                n_sort[2] = n[1];
            end
        end
    end

    // Mean of the four operands (rounded toward zero) and the mean-removed residuals.
    always_comb begin
        sum     = 6'(n[0]) + 6'(n[1]) + 6'(n[2]) + 6'(n[3]);
        // Bias negative sums by 3 so the arithmetic shift truncates toward zero.
        sum_adj = sum + (sum[5] ? 6'sd3 : 6'sd0);
        mean    = op[2] ? 4'(sum_adj >>> 2) : 4'sd0;
        for (int unsigned i = 0; i < 4; i++) begin
            r_next[i] = 5'(n[i]) - 5'(mean);
        end
    end

    // Final arithmetic on the residuals, 12-bit signed so no intermediate overflows.
    always_comb begin
        prod_a = ((12'(r[0]) * 12'(r[1])) <<< 1) + 12'(r[3]);
        prod_b = (((12'(r[2]) <<< 2) + 12'(r[3])) * 12'(r[1])) / 12'sd3;
        result = op[3] ? prod_a : prod_b;
    end

    // Control FSM with operand storage and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_n     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                n[i] <= '0;
                r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n[0]  <= $signed(in_data);
                        op    <= opt;
                        cnt   <= 2'd1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        n[cnt] <= $signed(in_data);
                        if (cnt == 2'd3) begin
                            cnt   <= 2'd0;
                            state <= SORT;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                SORT: begin
                    n   <= n_sort;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= MEAN;
                    end
                end
                MEAN: begin
                    r     <= r_next;
                    state <= CALC;
                end
                CALC: begin
                    out_valid <= 1'b1;
                    out_n     <= result[8:0];
                    state     <= OUT;
                end
                OUT: begin
                    out_valid <= 1'b0;
                    out_n     <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
